// File: rtl/fetch_pc_if.sv
// Fetch-PC control/status bundle: next-PC selection inputs toward the
// PC unit and the fetch address / status coming back from it.
// master = sequencer/decoder side, slave = the fetch_pc block.
interface fetch_pc_if;
    logic        en;
    logic        halt;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_cnt;
    logic [1:0]  state;
    logic        addr_err;

    modport master (
        output en, halt, npc_sel, br_taken, imm16, instr_index, rs_val,
        input  pc, pc_plus4, fetch_cnt, state, addr_err
    );

    modport slave (
        input  en, halt, npc_sel, br_taken, imm16, instr_index, rs_val,
        output pc, pc_plus4, fetch_cnt, state, addr_err
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: selects sequential / branch / jump /
// register next-PC, counts advances, and supports HALT and an optional
// illegal-target ERR state.
// Optional feature macro: FETCH_PC_RANGE_CHECK_EN -- when defined, a
// misaligned or out-of-memory next-PC is refused and the unit enters ERR.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic       clk,
    input  logic       reset,
    fetch_pc_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        ERR  = 2'b10
    } state_t;

`ifdef FETCH_PC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    // Legal fetch window [PC_LO, PC_HI), widened to 33 bits so the upper
    // bound cannot wrap when the memory sits at the top of the address map.
    localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
    localparam logic [32:0] PC_HI = PC_LO + (33'(IM_WORDS) << 2);

    logic [31:0]        pc_p1;
    logic [31:0]        cnt_p1;
    state_t             state_p1;
    logic               err_p1;

    logic [31:0]        pc_plus4_p0;
    logic signed [31:0] br_off_p0;
    logic [31:0]        npc_p0;
    logic               npc_ok_p0;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Word-aligned and inside the instruction memory.
    function automatic logic in_window(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} >= PC_LO) && ({1'b0, a} < PC_HI);
    endfunction

    assign pc_plus4_p0 = pc_p1 + 32'd4;
    assign br_off_p0   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

    // Next-PC source mux; all additions wrap modulo 2^32.
    always_comb begin
        npc_p0 = pc_plus4_p0;
        case (bus.npc_sel)
            2'b00: npc_p0 = pc_plus4_p0;
            2'b01: npc_p0 = bus.br_taken ? (pc_plus4_p0 + $unsigned(br_off_p0)) : pc_plus4_p0;
            2'b10: npc_p0 = {pc_plus4_p0[31:28], bus.instr_index, 2'b00};
            2'b11: npc_p0 = bus.rs_val;
            default: npc_p0 = pc_plus4_p0;
        endcase
    end

    assign npc_ok_p0 = !RANGE_CHECK || in_window(npc_p0);

    // RUN/HALT/ERR control with PC, counter and error flag registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p1    <= RESET_PC;
            cnt_p1   <= 32'd0;
            state_p1 <= RUN;
            err_p1   <= 1'b0;
        end else begin
            case (state_p1)
                RUN: begin
                    if (bus.halt) begin
                        state_p1 <= HALT;
                    end else if (bus.en) begin
                        if (npc_ok_p0) begin
                            pc_p1  <= npc_p0;
                            cnt_p1 <= sat_inc(cnt_p1);
                        end else begin
                            state_p1 <= ERR;
                            err_p1   <= 1'b1;
                        end
                    end
                end
                HALT: state_p1 <= HALT;
                ERR:  state_p1 <= ERR;
                default: state_p1 <= ERR;
            endcase
        end
    end

    assign bus.pc        = pc_p1;
    assign bus.pc_plus4  = pc_plus4_p0;
    assign bus.fetch_cnt = cnt_p1;
    assign bus.state     = state_p1;
    assign bus.addr_err  = err_p1;

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter IM_WORDS, default 1024, instruction-memory depth in 32-bit words, used for the legal-range check.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  advance enable; 0 = stall, PC holds.
REQ-006 halt  input  1  stop fetching; enters HALT.
REQ-007 npc_sel  input  2  next-PC source: 00 sequential, 01 branch, 10 jump (j/jal), 11 register (jr).
REQ-008 br_taken  input  1  branch condition; used only when npc_sel=01.
REQ-009 imm16  input  16  branch offset, in words.
REQ-010 instr_index  input  26  jump target field.
REQ-011 rs_val  input  32  register-jump target.
REQ-012 pc  output  32  current fetch address; drives the instruction memory address input.
REQ-013 pc_plus4  output  32  pc+4, combinational; link value for jal.
REQ-014 fetch_cnt  output  32  count of PC advances since reset.
REQ-015 state  output  2  00 RUN, 01 HALT, 10 ERR.
REQ-016 addr_err  output  1  sticky illegal-target flag.

Function
REQ-017 The next-PC value for npc_sel=00 SHALL be pc+4.
REQ-018 The next-PC value for npc_sel=01 SHALL be pc+4+(sign-extended imm16 << 2) when br_taken=1, and pc+4 when br_taken=0.
REQ-019 The next-PC value for npc_sel=10 SHALL be {pc_plus4[31:28], instr_index, 2'b00}.
REQ-020 The next-PC value for npc_sel=11 SHALL be rs_val.
REQ-021 All next-PC additions SHALL be modulo 2^32; wrap-around is silent.
REQ-022 In RUN with en=1 and halt=0, pc SHALL take the next-PC value at the clock edge; the latency from select inputs to the pc output is 1 cycle.
REQ-023 In RUN with en=0, pc, fetch_cnt and state SHALL hold.
REQ-024 When halt=1 in RUN, state SHALL become HALT at the next edge and pc SHALL hold, regardless of en; halt takes priority over any PC update.
REQ-025 HALT SHALL be absorbing until reset; pc and fetch_cnt hold, and all inputs are ignored.
REQ-026 fetch_cnt SHALL increment by 1 on every edge at which pc is updated, and SHALL saturate at 32'hFFFF_FFFF.
REQ-027 pc_plus4 SHALL always equal pc+4, including in HALT and ERR.

Reset
REQ-028 On reset assertion, immediately and independent of clk: pc=RESET_PC, fetch_cnt=0, state=RUN, addr_err=0.
REQ-029 Reset asserted in mid-operation (including in HALT or ERR) SHALL abort the operation with no partial update.
REQ-030 The first pc update SHALL occur on the first rising edge after reset deasserts, provided en=1.

Configuration
REQ-031 Macro FETCH_PC_RANGE_CHECK_EN, when defined, SHALL reject any next-PC that has bits [1:0]!=0 or lies outside [RESET_PC, RESET_PC+4*IM_WORDS).
REQ-032 On a rejected next-PC, pc SHALL hold, fetch_cnt SHALL not increment, state SHALL become ERR and addr_err SHALL become 1.
REQ-033 ERR SHALL be absorbing until reset; it is checked only on an edge where an update would otherwise occur, and halt in the same cycle takes priority.
REQ-034 When FETCH_PC_RANGE_CHECK_EN is undefined, no check SHALL be performed, addr_err SHALL be constant 0, and ERR is unreachable.

Verification
REQ-035 Release reset, en=1, npc_sel=00 for 3 cycles -> pc goes 3000, 3004, 3008, 300C; fetch_cnt=3.
REQ-036 pc=3010, npc_sel=01, br_taken=1, imm16=16'hFFFE -> pc=300C; with br_taken=0 -> pc=3014.
REQ-037 pc=3000, npc_sel=10, instr_index=26'h0000C08 -> pc=00003020; npc_sel=11, rs_val=3040 -> pc=3040.
REQ-038 en=0 for 2 cycles, then halt=1 together with en=1 -> pc unchanged and state=HALT; reset pulse mid-cycle -> pc=3000 and state=RUN immediately.
REQ-039 With FETCH_PC_RANGE_CHECK_EN defined, npc_sel=11 and rs_val=3002 -> pc holds, addr_err=1, state=ERR.
REQ-040 With FETCH_PC_RANGE_CHECK_EN defined, rs_val=4000 (past 1024 words) -> pc holds, addr_err=1, state=ERR; without the macro -> pc=4000 and addr_err=0.
